window3x3_ctrl: RTL and testbench
=================================

# window3x3_ctrl

Sequencer for the 3×3 mean-filter datapath. It accepts a raster-order 8-bit pixel stream and keeps two line buffers. For every pixel position where a full 3×3 neighbourhood exists, it presents the nine window pixels, in the order the mean block expects, behind a valid/ready handshake. It sits between the image source (camera/BRAM reader) and the averaging stage of the dehazing pipeline, and it owns all row/column counting and frame sequencing for that stage.

## Interface
- IMG_W, 640, pixels per line (≥ 3)
- IMG_H, 480, lines per frame (≥ 3)
- DW, 8, pixel width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  source pixel valid
- in_data  in  DW  source pixel
- in_ready  out  1  controller can accept pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- win_data  out  9*DW  window; slot k at [k*DW +: DW], k=0..8 row-major, 0 = top-left (oldest row, oldest column), 8 = bottom-right (current pixel); slot k drives mean input in<k>
- out_eof  out  1  qualifies the last window of a frame (valid with out_valid)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- busy  out  1  high in FILL or STREAM

## Operation
- Pixel accepted when in_valid && in_ready. Window taken when out_valid && out_ready.
- Counters:
  - col: 0..IMG_W-1. Increments per accepted pixel and wraps to 0, which advances row.
  - row: 0..IMG_H-1. Wraps to 0 at end of frame.
- Line buffers:
  - lb1 holds the previous line; lb0 holds the line before that. Both are IMG_W deep.
  - On accept: lb0[col] ← lb1[col], lb1[col] ← in_data.
- Column shift registers: three rows × 2 previous columns, fed by {lb0[col], lb1[col], in_data}.
- Window emit condition: accepted pixel has row ≥ 2 && col ≥ 2. On accept, win_data and out_valid are loaded.
  - Result: (IMG_H-2)·(IMG_W-2) windows per frame.
  - Border positions produce no window; this is the frame-size contract with downstream.
- out_eof is set with the window at row = IMG_H-1, col = IMG_W-1.
- FSM:
  - IDLE → FILL on first accepted pixel.
  - FILL → STREAM when the pixel at row 2, col 0 is accepted.
  - STREAM → DONE when the pixel at row IMG_H-1, col IMG_W-1 is accepted.
  - DONE → IDLE after one cycle; frame_done = 1 in DONE.
  - in_ready = 0 in DONE, so the next frame starts no earlier than the cycle after.
- Backpressure:
  - in_ready = (state ≠ DONE) && (!out_valid || out_ready).
  - Pixels that do not emit are still gated by the same rule, which keeps column alignment trivial.
- Arithmetic: counters are $clog2 of their limit. No saturation; wraps are explicit compares to IMG_W-1 / IMG_H-1.
- Reset (any time, including mid-frame):
  - Immediately: state = IDLE; col, row = 0; out_valid, out_eof, frame_done = 0; win_data = 0; busy = 0; in_ready = 1 after reset deassertion.
  - Line-buffer contents are not cleared; they are overwritten before use.

## Timing
- Latency: window appears on out_valid the cycle after its completing pixel is accepted (1 cycle).
- Throughput: 1 pixel/cycle when out_ready is held high.
- Output hold: win_data, out_valid and out_eof stay stable while out_valid && !out_ready.
- Simultaneous out take and pixel accept in the same cycle: the register is reloaded (or out_valid cleared if the new pixel does not emit).
- Line buffer: synchronous-read RAM is not allowed unless the read is pipelined. The baseline implementation uses asynchronous-read registers or LUTRAM, so lb read and write happen in the accept cycle.
- frame_done asserts the cycle after the last pixel is accepted, concurrent with the final out_valid/out_eof.

## Structure
- Package dehaze_pkg: DW default and window slot index constants. FSM enum {IDLE, FILL, STREAM, DONE} is defined as a 2-bit typedef there.
- One sub-module: line_buffer (parameters DEPTH, DW). Ports: clk, we, addr, wdata, rdata (async read). Instantiated twice.
- The mean datapath is not instantiated here; the top level wires win_data slots to it.

## Test plan
- IMG_W=4, IMG_H=4, pixel value = row·4+col, out_ready=1 → first window at pixel 10 = {0,1,2,4,5,6,8,9,10}; exactly 4 windows total; last = {5,6,7,9,10,11,13,14,15} with out_eof=1.
- Same image, out_ready low for 3 cycles while a window is pending → in_ready=0, win_data held unchanged, no pixel lost; window sequence identical to the first test.
- Two back-to-back frames → frame_done pulses once per frame; in_ready=0 for exactly one cycle (DONE); second frame's first window = {0,1,2,4,5,6,8,9,10}.
- rst_n asserted at row 2, col 3 → all outputs 0 immediately, state IDLE; a fresh frame afterwards yields correct windows with no stale data.
- Random in_valid gaps (50%) with IMG_W=5, IMG_H=3 → exactly 3 windows, matching a scoreboard computed from the accepted-pixel order.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehazing pipeline's 3x3 window stage.
package dehaze_pkg;

   // Default pixel width of the pipeline.
   localparam int DW_DEFAULT = 8;

   // Window geometry: rows top (oldest) to bottom (current), columns left (oldest) to right.
   // Slot k of the window is at row k / WIN_COLS, column k % WIN_COLS.
   localparam int WIN_ROWS  = 3;
   localparam int WIN_COLS  = 3;
   localparam int WIN_SLOTS = WIN_ROWS * WIN_COLS;

   // Frame sequencing states of the window controller.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: synchronous write, asynchronous read at the same address.
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // Store the new pixel; contents are never cleared, every entry is rewritten before it is read for a window.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   assign rdata = r_mem[addr];

endmodule

// File: rtl/window3x3_ctrl.sv
// Raster pixel stream in, 3x3 neighbourhoods out (interior positions only), with frame sequencing.
module window3x3_ctrl
   import dehaze_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = DW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DW-1:0]          in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIN_SLOTS*DW-1:0] win_data,
   output logic                   out_eof,
   output logic                   frame_done,
   output logic                   busy
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CW-1:0]           r_col;
   logic [RW-1:0]           r_row;
   logic                    r_out_valid;
   logic                    r_out_eof;
   logic [WIN_SLOTS*DW-1:0] r_win_data;

   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_emit;
   logic                    w_last_px;
   logic                    w_busy;
   logic                    w_frame_done;
   logic [DW-1:0]           w_lb0_rd;
   logic [DW-1:0]           w_lb1_rd;
   logic [DW-1:0]           w_col_new [WIN_ROWS];
   logic [WIN_SLOTS*DW-1:0] w_win;

   // A pixel is taken only when the output register is free or being emptied this cycle.
   assign w_in_ready = (r_state != DONE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_emit     = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
   assign w_last_px  = (r_row == ROW_LAST) && (r_col == COL_LAST);

   // lb1 holds the previous line, lb0 the one before; both shift down by one line on every accept.
   line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
      .clk   (clk),
      .we    (w_accept),
      .addr  (r_col),
      .wdata (w_lb1_rd),
      .rdata (w_lb0_rd)
   );

   line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
      .clk   (clk),
      .we    (w_accept),
      .addr  (r_col),
      .wdata (in_data),
      .rdata (w_lb1_rd)
   );

   // Newest column of the window, top row (oldest line) first.
   assign w_col_new[0] = w_lb0_rd;
   assign w_col_new[1] = w_lb1_rd;
   assign w_col_new[2] = in_data;

   generate
      for (genvar gi = 0; gi < WIN_ROWS; gi++) begin : g_row
         logic [DW-1:0] r_old;
         logic [DW-1:0] r_mid;

         // Keep the two previous columns of this window row; only valid once col >= 2.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_old <= '0;
               r_mid <= '0;
            end else if (w_accept) begin
               r_old <= r_mid;
               r_mid <= w_col_new[gi];
            end
         end

         assign w_win[(gi*WIN_COLS + 0)*DW +: DW] = r_old;
         assign w_win[(gi*WIN_COLS + 1)*DW +: DW] = r_mid;
         assign w_win[(gi*WIN_COLS + 2)*DW +: DW] = w_col_new[gi];
      end
   endgenerate

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Output register: loaded by an emitting pixel, cleared when taken without a replacement, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
         r_win_data  <= '0;
      end else if (w_accept) begin
         r_out_valid <= w_emit;
         r_out_eof   <= w_emit && w_last_px;
         if (w_emit) begin
            r_win_data <= w_win;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_out_eof   <= 1'b0;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Frame sequencing: fill the line buffers, stream windows, then one DONE cycle that blocks input.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_next = FILL;
         end
         FILL: begin
            w_busy = 1'b1;
            if (w_accept && (r_row == ROW_TWO) && (r_col == '0)) w_state_next = STREAM;
         end
         STREAM: begin
            w_busy = 1'b1;
            if (w_accept && w_last_px) w_state_next = DONE;
         end
         DONE: begin
            w_frame_done = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_eof    = r_out_eof;
   assign win_data   = r_win_data;
   assign frame_done = w_frame_done;
   assign busy       = w_busy;

endmodule

// File: tb/tb_window3x3_ctrl.sv
// Bench for window3x3_ctrl: a 4x4 instance and a 5x3 instance checked against a raster-image model.
module tb_window3x3_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv0, ir0, ov0, or0, eof0, fd0, busy0;
   logic [7:0]  id0;
   logic [71:0] wd0;
   logic        iv1, ir1, ov1, or1, eof1, fd1, busy1;
   logic [7:0]  id1;
   logic [71:0] wd1;

   window3x3_ctrl #(.IMG_W(4), .IMG_H(4), .DW(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
      .out_valid(ov0), .out_ready(or0), .win_data(wd0), .out_eof(eof0),
      .frame_done(fd0), .busy(busy0)
   );

   window3x3_ctrl #(.IMG_W(5), .IMG_H(3), .DW(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .out_valid(ov1), .out_ready(or1), .win_data(wd1), .out_eof(eof1),
      .frame_done(fd1), .busy(busy1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model state, indexed by instance (0 = 4x4, 1 = 5x3).
   int          mw [2] = '{4, 5};
   int          mh [2] = '{4, 3};
   int          pix [2][8][8];
   int          fcnt [2];
   logic [71:0] exp_win [2][64];
   logic        exp_eof [2][64];
   int          exp_wr [2];
   int          exp_rd [2];
   logic [71:0] got_win [2][64];
   logic        got_eof [2][64];
   int          ngot [2];
   bit          fd_exp [2];
   bit          ov_exp [2];
   bit          hold_v [2];
   bit          hold_eof [2];
   logic [71:0] hold_win [2];
   int          fd_seen [2];
   int          lowir [2];
   logic [71:0] ref_win [4];

   task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [71:0] mk9(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
      logic [71:0] w;
      w = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
      return w;
   endfunction

   // One cycle of the model for one instance, sampled at the falling edge.
   task automatic step(input int id, input logic rstn, input logic iv, input logic [7:0] idata,
                       input logic ir, input logic ov, input logic ordy, input logic [71:0] wd,
                       input logic eof, input logic fd, input logic bsy);
      int r;
      int c;
      logic [71:0] w;
      if (!rstn) begin
         check($sformatf("rst_out_valid%0d", id), 72'(ov), 72'(0));
         check($sformatf("rst_win_data%0d", id), wd, 72'(0));
         check($sformatf("rst_eof%0d", id), 72'(eof), 72'(0));
         check($sformatf("rst_frame_done%0d", id), 72'(fd), 72'(0));
         check($sformatf("rst_busy%0d", id), 72'(bsy), 72'(0));
         fcnt[id] = 0; exp_wr[id] = 0; exp_rd[id] = 0;
         fd_exp[id] = 0; ov_exp[id] = 0; hold_v[id] = 0;
         return;
      end
      if (hold_v[id]) begin
         check($sformatf("hold_win%0d", id), wd, hold_win[id]);
         check($sformatf("hold_valid%0d", id), 72'(ov), 72'(1));
         check($sformatf("hold_eof%0d", id), 72'(eof), 72'(hold_eof[id]));
      end
      if (ov_exp[id]) check($sformatf("latency_valid%0d", id), 72'(ov), 72'(1));
      check($sformatf("frame_done%0d", id), 72'(fd), 72'(fd_exp[id]));
      check($sformatf("busy%0d", id), 72'(bsy), 72'(fcnt[id] != 0));
      check($sformatf("in_ready%0d", id), 72'(ir), 72'(!fd_exp[id] && (!ov || ordy)));
      if (fd) fd_seen[id]++;
      if (!ir) lowir[id]++;
      if (ov && ordy) begin
         if (exp_rd[id] == exp_wr[id]) begin
            check($sformatf("unexpected_window%0d", id), 72'(1), 72'(0));
         end else begin
            check($sformatf("win_data%0d", id), wd, exp_win[id][exp_rd[id] % 64]);
            check($sformatf("win_eof%0d", id), 72'(eof), 72'(exp_eof[id][exp_rd[id] % 64]));
            exp_rd[id]++;
         end
         got_win[id][ngot[id] % 64] = wd;
         got_eof[id][ngot[id] % 64] = eof;
         ngot[id]++;
      end
      hold_v[id]   = ov && !ordy;
      hold_win[id] = wd;
      hold_eof[id] = eof;
      fd_exp[id]   = 0;
      ov_exp[id]   = 0;
      if (iv && ir) begin
         r = fcnt[id] / mw[id];
         c = fcnt[id] % mw[id];
         pix[id][r][c] = int'(idata);
         if (r >= 2 && c >= 2) begin
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  w[(dr*3 + dc)*8 +: 8] = 8'(pix[id][r-2+dr][c-2+dc]);
            exp_win[id][exp_wr[id] % 64] = w;
            exp_eof[id][exp_wr[id] % 64] = (r == mh[id] - 1) && (c == mw[id] - 1);
            exp_wr[id]++;
            ov_exp[id] = 1;
         end
         if (fcnt[id] == mw[id] * mh[id] - 1) begin
            fcnt[id]   = 0;
            fd_exp[id] = 1;
         end else begin
            fcnt[id]++;
         end
      end
   endtask

   always @(negedge clk) begin
      step(0, rst_n, iv0, id0, ir0, ov0, or0, wd0, eof0, fd0, busy0);
      step(1, rst_n, iv1, id1, ir1, ov1, or1, wd1, eof1, fd1, busy1);
   end

   task automatic drive(input int id, input logic v, input logic [7:0] d);
      if (id == 0) begin iv0 = v; id0 = d; end
      else         begin iv1 = v; id1 = d; end
   endtask

   // Send npix raster pixels (value base+index, or random); called and returns at posedge+1.
   task automatic send_frame(input int id, input int base, input bit rnd, input int gap_pct, input int npix);
      logic [7:0] v;
      bit done;
      bit gap;
      int tries;
      for (int p = 0; p < npix; p++) begin
         v = rnd ? 8'($urandom_range(0, 255)) : 8'(base + p);
         done = 0;
         tries = 0;
         while (!done) begin
            gap = (gap_pct > 0) && ($urandom_range(0, 99) < gap_pct);
            drive(id, !gap, v);
            @(negedge clk);
            done = !gap && ((id == 0) ? ir0 : ir1);
            @(posedge clk); #1;
            tries++;
            if (!done && tries > 200) begin
               check("drive_timeout", 72'(0), 72'(1));
               drive(id, 1'b0, 8'd0);
               return;
            end
         end
      end
      drive(id, 1'b0, 8'd0);
   endtask

   // Hold out_ready low for three cycles once a window is pending on instance 0.
   task automatic stall3();
      logic [71:0] held;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ov0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!ov0) check("stall_wait_timeout", 72'(0), 72'(1));
      check("stall_in_ready", 72'(ir0), 72'(0));
      held = wd0;
      repeat (2) begin
         @(negedge clk);
         check("stall_in_ready", 72'(ir0), 72'(0));
         check("stall_hold", wd0, held);
      end
      @(posedge clk); #1;
      or0 = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      iv0 = 0; id0 = 0; or0 = 1;
      iv1 = 0; id1 = 0; or1 = 1;
      rst_n = 0;
      for (int i = 0; i < 2; i++) begin
         ngot[i] = 0; fd_seen[i] = 0; lowir[i] = 0;
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      @(posedge clk); #1;
      check("post_reset_in_ready0", 72'(ir0), 72'(1));
      check("post_reset_in_ready1", 72'(ir1), 72'(1));

      // Basic 4x4 frame, out_ready held high.
      ngot[0] = 0;
      send_frame(0, 0, 0, 0, 16);
      repeat (4) @(posedge clk); #1;
      check("t1_count", 72'(ngot[0]), 72'(4));
      check("t1_first", got_win[0][0], mk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check("t1_first_eof", 72'(got_eof[0][0]), 72'(0));
      check("t1_last", got_win[0][3], mk9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      check("t1_last_eof", 72'(got_eof[0][3]), 72'(1));
      for (int i = 0; i < 4; i++) ref_win[i] = got_win[0][i];

      // Same frame with a three-cycle downstream stall.
      ngot[0] = 0;
      or0 = 1'b0;
      fork
         send_frame(0, 0, 0, 0, 16);
         stall3();
      join
      repeat (4) @(posedge clk); #1;
      check("t2_count", 72'(ngot[0]), 72'(4));
      for (int i = 0; i < 4; i++) check($sformatf("t2_seq%0d", i), got_win[0][i], ref_win[i]);

      // Two back-to-back frames.
      ngot[0] = 0; fd_seen[0] = 0; lowir[0] = 0;
      send_frame(0, 0, 0, 0, 16);
      send_frame(0, 0, 0, 0, 16);
      repeat (4) @(posedge clk); #1;
      check("t3_frame_done_pulses", 72'(fd_seen[0]), 72'(2));
      check("t3_in_ready_low_cycles", 72'(lowir[0]), 72'(2));
      check("t3_count", 72'(ngot[0]), 72'(8));
      check("t3_second_first", got_win[0][4], mk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check("t3_second_last_eof", 72'(got_eof[0][7]), 72'(1));

      // Reset mid-frame right after the pixel at row 2, col 3.
      ngot[0] = 0;
      send_frame(0, 0, 0, 0, 12);
      check("t4_pending_valid", 72'(ov0), 72'(1));
      check("t4_pending_win", wd0, mk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      #2 rst_n = 0;
      #1;
      check("t4_rst_valid", 72'(ov0), 72'(0));
      check("t4_rst_win", wd0, 72'(0));
      check("t4_rst_eof", 72'(eof0), 72'(0));
      check("t4_rst_frame_done", 72'(fd0), 72'(0));
      check("t4_rst_busy", 72'(busy0), 72'(0));
      check("t4_rst_in_ready", 72'(ir0), 72'(1));
      @(posedge clk); #3 rst_n = 1;
      @(posedge clk); #1;
      ngot[0] = 0;
      send_frame(0, 100, 0, 0, 16);
      repeat (4) @(posedge clk); #1;
      check("t4_count", 72'(ngot[0]), 72'(4));
      check("t4_first", got_win[0][0], mk9(100, 101, 102, 104, 105, 106, 108, 109, 110));
      check("t4_last", got_win[0][3], mk9(105, 106, 107, 109, 110, 111, 113, 114, 115));

      // 5x3 frame with random input gaps and random pixel values.
      ngot[1] = 0;
      send_frame(1, 0, 1, 50, 15);
      repeat (4) @(posedge clk); #1;
      check("t5_count", 72'(ngot[1]), 72'(3));
      check("t5_first_eof", 72'(got_eof[1][0]), 72'(0));
      check("t5_last_eof", 72'(got_eof[1][2]), 72'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
